// File: rtl/sram_d_obi_arb.sv
// Two-master round-robin OBI arbiter in front of the SRAM wrapper data port.
// Optional perf counters are enabled with `define SRAM_ARB_PERF_EN.
module sram_d_obi_arb #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    output logic              m0_gnt_o,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_be_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    output logic              m1_gnt_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_be_i,
    input  logic [31:0]       m1_wdata_i,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic              m1_err_o,
    output logic              sram_d_req_o,
    input  logic              sram_d_gnt_i,
    output logic [ADDR_W-1:0] sram_d_addr_o,
    output logic              sram_d_we_o,
    output logic [3:0]        sram_d_be_o,
    output logic [31:0]       sram_d_wdata_o,
    input  logic              sram_d_rvalid_i,
    input  logic [31:0]       sram_d_rdata_i,
    input  logic              illegal_memory_i,
    output logic              spurious_rvalid_o
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_m0_gnt_o,
    output logic [31:0]       perf_m1_gnt_o,
    output logic [31:0]       perf_conflict_o
`endif
);

    localparam int IDX_W = $clog2(MAX_OUTSTANDING);
    localparam int PTR_W = IDX_W + 1;

    // Entry layout: bit 1 = master id, bit 0 = latched illegal flag.
    logic [1:0]       fifo_q [MAX_OUTSTANDING];
    logic [1:0]       fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             last_m1_q, last_m1_d;
    logic             spur_q, spur_d;

    logic             fifo_empty, fifo_full;
    logic             any_req, sel_m1, handshake, pop;
    logic [1:0]       head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    assign any_req = m0_req_i | m1_req_i;
    assign sel_m1  = (m0_req_i & m1_req_i) ? ~last_m1_q : m1_req_i;

    // Full blocks forwarding outright so rvalid never feeds the request path.
    assign sram_d_req_o = any_req & ~fifo_full & rst_ni;
    assign handshake    = sram_d_req_o & sram_d_gnt_i;
    assign m0_gnt_o     = handshake & ~sel_m1;
    assign m1_gnt_o     = handshake & sel_m1;

    always_comb begin
        sram_d_addr_o  = '0;
        sram_d_we_o    = 1'b0;
        sram_d_be_o    = '0;
        sram_d_wdata_o = '0;
        if (any_req) begin
            sram_d_addr_o  = sel_m1 ? m1_addr_i  : m0_addr_i;
            sram_d_we_o    = sel_m1 ? m1_we_i    : m0_we_i;
            sram_d_be_o    = sel_m1 ? m1_be_i    : m0_be_i;
            sram_d_wdata_o = sel_m1 ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign pop  = sram_d_rvalid_i & ~fifo_empty;
    assign head = fifo_q[rd_ptr_q[IDX_W-1:0]];

    assign m0_rvalid_o = pop & ~head[1];
    assign m1_rvalid_o = pop & head[1];
    assign m0_rdata_o  = m0_rvalid_o ? sram_d_rdata_i : 32'h0;
    assign m1_rdata_o  = m1_rvalid_o ? sram_d_rdata_i : 32'h0;
    assign m0_err_o    = m0_rvalid_o & head[0];
    assign m1_err_o    = m1_rvalid_o & head[0];
    assign spurious_rvalid_o = spur_q;

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        last_m1_d = last_m1_q;
        spur_d    = spur_q | (sram_d_rvalid_i & fifo_empty);
        if (handshake) begin
            fifo_d[wr_ptr_q[IDX_W-1:0]] = {sel_m1, illegal_memory_i};
            wr_ptr_d  = wr_ptr_q + 1'b1;
            last_m1_d = sel_m1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            last_m1_q <= 1'b1;
            spur_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            last_m1_q <= last_m1_d;
            spur_q    <= spur_d;
        end
    end

    // Entry storage is qualified by the pointers and needs no reset.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_m0_q, perf_m0_d;
    logic [31:0] perf_m1_q, perf_m1_d;
    logic [31:0] perf_cf_q, perf_cf_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        perf_m0_d = m0_gnt_o ? sat_inc(perf_m0_q) : perf_m0_q;
        perf_m1_d = m1_gnt_o ? sat_inc(perf_m1_q) : perf_m1_q;
        perf_cf_d = (m0_req_i & m1_req_i) ? sat_inc(perf_cf_q) : perf_cf_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_m0_q <= '0;
            perf_m1_q <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_m0_q <= perf_m0_d;
            perf_m1_q <= perf_m1_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_m0_gnt_o   = perf_m0_q;
    assign perf_m1_gnt_o   = perf_m1_q;
    assign perf_conflict_o = perf_cf_q;
`endif

endmodule

// File: tb/tb_sram_d_obi_arb.sv
// Directed plus randomized bench for sram_d_obi_arb with a queue-based reference model.
module tb_sram_d_obi_arb;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        s_gnt = 0, s_rvalid = 0, illegal = 0;
    logic [31:0] s_rdata = 0;
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        s_req, s_we, spur_o;
    logic [3:0]  s_be;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf0_o, perf1_o, perfc_o;
`endif

    sram_d_obi_arb #(.MAX_OUTSTANDING(MAXO), .ADDR_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rdata),
        .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rdata),
        .m1_err_o(m1_err),
        .sram_d_req_o(s_req), .sram_d_gnt_i(s_gnt), .sram_d_addr_o(s_addr),
        .sram_d_we_o(s_we), .sram_d_be_o(s_be), .sram_d_wdata_o(s_wdata),
        .sram_d_rvalid_i(s_rvalid), .sram_d_rdata_i(s_rdata),
        .illegal_memory_i(illegal), .spurious_rvalid_o(spur_o)
`ifdef SRAM_ARB_PERF_EN
        , .perf_m0_gnt_o(perf0_o), .perf_m1_gnt_o(perf1_o), .perf_conflict_o(perfc_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: outstanding responses as an ordered list of owners.
    int unsigned q_id[$];
    bit          q_il[$];
    bit          last_m1 = 1'b1;
    bit          spur = 1'b0;
    bit          e_hs, e_sel1, e_pop, g0_last, g1_last;
    int unsigned perf0 = 0, perf1 = 0, perfc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_id.delete();
        q_il.delete();
        last_m1 = 1'b1;
        spur = 1'b0;
        perf0 = 0; perf1 = 0; perfc = 0;
    endtask

    task automatic check_cycle();
        bit full, any, e_req, r0, r1, ril;
        #4;
        full   = (q_id.size() >= MAXO);
        any    = m0_req || m1_req;
        e_sel1 = (m0_req && m1_req) ? !last_m1 : m1_req;
        e_req  = any && !full;
        e_hs   = e_req && s_gnt;
        e_pop  = s_rvalid && (q_id.size() > 0);
        r0  = e_pop && (q_id[0] == 0);
        r1  = e_pop && (q_id[0] == 1);
        ril = e_pop && q_il[0];
        chk("sram_req", s_req, e_req);
        chk("m0_gnt", m0_gnt, e_hs && !e_sel1);
        chk("m1_gnt", m1_gnt, e_hs && e_sel1);
        if (e_req) begin
            chk("addr",  s_addr,  e_sel1 ? m1_addr  : m0_addr);
            chk("we",    s_we,    e_sel1 ? m1_we    : m0_we);
            chk("be",    s_be,    e_sel1 ? m1_be    : m0_be);
            chk("wdata", s_wdata, e_sel1 ? m1_wdata : m0_wdata);
        end
        chk("m0_rvalid", m0_rv, r0);
        chk("m1_rvalid", m1_rv, r1);
        chk("m0_rdata", m0_rdata, r0 ? s_rdata : 32'h0);
        chk("m1_rdata", m1_rdata, r1 ? s_rdata : 32'h0);
        chk("m0_err", m0_err, r0 && ril);
        chk("m1_err", m1_err, r1 && ril);
        chk("spurious", spur_o, spur);
`ifdef SRAM_ARB_PERF_EN
        chk("perf_m0", perf0_o, perf0);
        chk("perf_m1", perf1_o, perf1);
        chk("perf_conflict", perfc_o, perfc);
`endif
    endtask

    task automatic finish_cycle();
        if (m0_req && m1_req) perfc++;
        if (e_pop) begin
            void'(q_id.pop_front());
            void'(q_il.pop_front());
        end else if (s_rvalid) begin
            spur = 1'b1;
        end
        if (e_hs) begin
            q_id.push_back(e_sel1 ? 1 : 0);
            q_il.push_back(illegal);
            last_m1 = e_sel1;
            if (e_sel1) perf1++; else perf0++;
        end
        g0_last = e_hs && !e_sel1;
        g1_last = e_hs && e_sel1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        check_cycle();
        finish_cycle();
    endtask

    task automatic drain();
        m0_req = 0; m1_req = 0; s_gnt = 0;
        for (int k = 0; k < 8 && q_id.size() > 0; k++) begin
            s_rvalid = 1; s_rdata = $urandom;
            tick();
        end
        s_rvalid = 0;
    endtask

    initial begin
        // Reset: outputs quiet even with a master requesting.
        m0_req = 1; s_gnt = 1;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_sram_req", s_req, 0);
        chk("rst_m0_rvalid", m0_rv, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_spurious", spur_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1; m0_req = 0; s_gnt = 0;
        model_reset();

        // Contention: both masters hold requests, grants must alternate from m0.
        m0_req = 1; m1_req = 1; s_gnt = 1;
        m0_addr = 32'h100; m1_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            s_rvalid = (k > 0); s_rdata = 32'hA000 + k;
            check_cycle();
            chk("cont_m0_gnt", m0_gnt, (k % 2) == 0);
            chk("cont_m1_gnt", m1_gnt, (k % 2) == 1);
            if (k > 0) chk("cont_route_m1", m1_rv, (k % 2) == 0);
            finish_cycle();
        end
        drain();

        // Single-master read.
        m0_req = 1; m0_addr = 32'h8000_0010; m0_we = 0; m0_be = 4'hF; s_gnt = 1;
        check_cycle();
        chk("t1_m0_gnt", m0_gnt, 1);
        finish_cycle();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        check_cycle();
        chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_m1_rvalid", m1_rv, 0);
        finish_cycle();
        s_rvalid = 0;

        // Illegal write followed by a legal one on m1.
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_1000; m1_wdata = 32'h1234; illegal = 1; s_gnt = 1;
        tick();
        m1_req = 1; m1_addr = 32'h0000_2000; illegal = 0; s_rvalid = 1;
        check_cycle();
        chk("ill_m1_err", m1_err, 1);
        finish_cycle();
        m1_req = 0; s_gnt = 0;
        check_cycle();
        chk("legal_m1_err", m1_err, 0);
        chk("legal_m1_rvalid", m1_rv, 1);
        finish_cycle();
        s_rvalid = 0; m1_we = 0;

        // Full: two grants, then stall until a response frees a slot.
        m0_req = 1; m0_addr = 32'h40; s_gnt = 1;
        tick();
        tick();
        check_cycle();
        chk("full_req_blocked", s_req, 0);
        finish_cycle();
        s_rvalid = 1;
        check_cycle();
        chk("full_no_req_on_pop", s_req, 0);
        finish_cycle();
        s_rvalid = 0;
        check_cycle();
        chk("full_resume", m0_gnt, 1);
        finish_cycle();
        drain();

        // Randomized traffic.
        g0_last = 0; g1_last = 0;
        for (int i = 0; i < 400; i++) begin
            if (!m0_req || g0_last) begin
                m0_req = ($urandom % 3) != 0; m0_addr = $urandom; m0_we = $urandom;
                m0_be = $urandom; m0_wdata = $urandom;
            end
            if (!m1_req || g1_last) begin
                m1_req = ($urandom % 3) != 0; m1_addr = $urandom; m1_we = $urandom;
                m1_be = $urandom; m1_wdata = $urandom;
            end
            s_gnt = ($urandom % 4) != 0;
            s_rvalid = (q_id.size() > 0) && (($urandom % 5) < 3);
            s_rdata = $urandom;
            illegal = ($urandom % 5) == 0;
            tick();
        end
        illegal = 0;
        drain();

        // Spurious rvalid with nothing outstanding.
        s_rvalid = 1; s_rdata = 32'h5555;
        tick();
        s_rvalid = 0;
        check_cycle();
        chk("spur_set", spur_o, 1);
        finish_cycle();
        tick();

        // Reset with two requests in flight.
        m0_req = 1; s_gnt = 1;
        tick();
        tick();
        m1_req = 1;
        rst_n = 0;
        #4;
        chk("mid_rst_m0_gnt", m0_gnt, 0);
        chk("mid_rst_m1_gnt", m1_gnt, 0);
        chk("mid_rst_sram_req", s_req, 0);
        chk("mid_rst_spurious", spur_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        check_cycle();
        chk("post_rst_tie_m0", m0_gnt, 1);
        finish_cycle();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 1;
        tick();
        tick();
        s_rvalid = 0;
        check_cycle();
        chk("post_rst_spurious", spur_o, 1);
        finish_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
